// File: rtl/aurora_pkg.sv
// Shared types and K-code constants for the per-lane 8b/10b encoder.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package aurora_pkg;

    typedef enum logic {
        RD_NEG = 1'b0,
        RD_POS = 1'b1
    } rd_e;

    localparam int ENCODER_DATA_IN_SIZE  = 8;
    localparam int ENCODER_DATA_OUT_SIZE = 10;

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // True for the twelve control characters the encoder can emit.
    function automatic logic k_code_ok(input logic [7:0] b);
        return (b == K28_0) || (b == K28_1) || (b == K28_2) || (b == K28_3) ||
               (b == K28_4) || (b == K28_5) || (b == K28_6) || (b == K28_7) ||
               (b == K23_7) || (b == K27_7) || (b == K29_7) || (b == K30_7);
    endfunction

endpackage

// File: rtl/enc_5b6b_3b4b.sv
// Combinational 8b/10b symbol encoder: byte + K flag + RD in, symbol + RD out.
// Latency: 0 cycles (pure logic, registered by the parent).
// Backpressure: none; the parent decides when the result is consumed.
module enc_5b6b_3b4b
    import aurora_pkg::*;
(
    input  logic [7:0] data,
    input  logic       k,
    input  rd_e        rd_in,
    output logic [9:0] symbol,
    output rd_e        rd_out,
    output logic       k_err
);

    // {unbalanced, abcdei as sent at RD-}; RD+ form is the complement for
    // unbalanced codes and for D.07.
    function automatic logic [6:0] code6_neg(input logic [4:0] x);
        case (x)
            5'd0:    return {1'b1, 6'b100111};
            5'd1:    return {1'b1, 6'b011101};
            5'd2:    return {1'b1, 6'b101101};
            5'd3:    return {1'b0, 6'b110001};
            5'd4:    return {1'b1, 6'b110101};
            5'd5:    return {1'b0, 6'b101001};
            5'd6:    return {1'b0, 6'b011001};
            5'd7:    return {1'b0, 6'b111000};
            5'd8:    return {1'b1, 6'b111001};
            5'd9:    return {1'b0, 6'b100101};
            5'd10:   return {1'b0, 6'b010101};
            5'd11:   return {1'b0, 6'b110100};
            5'd12:   return {1'b0, 6'b001101};
            5'd13:   return {1'b0, 6'b101100};
            5'd14:   return {1'b0, 6'b011100};
            5'd15:   return {1'b1, 6'b010111};
            5'd16:   return {1'b1, 6'b011011};
            5'd17:   return {1'b0, 6'b100011};
            5'd18:   return {1'b0, 6'b010011};
            5'd19:   return {1'b0, 6'b110010};
            5'd20:   return {1'b0, 6'b001011};
            5'd21:   return {1'b0, 6'b101010};
            5'd22:   return {1'b0, 6'b011010};
            5'd23:   return {1'b1, 6'b111010};
            5'd24:   return {1'b1, 6'b110011};
            5'd25:   return {1'b0, 6'b100110};
            5'd26:   return {1'b0, 6'b010110};
            5'd27:   return {1'b1, 6'b110110};
            5'd28:   return {1'b0, 6'b001110};
            5'd29:   return {1'b1, 6'b101110};
            5'd30:   return {1'b1, 6'b011110};
            default: return {1'b1, 6'b101011};
        endcase
    endfunction

    logic [7:0] code;
    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic [6:0] t6;
    logic       inv6;
    logic [5:0] abcdei;
    rd_e        rd_mid;
    logic       alt7;
    logic [3:0] fghj_neg;
    logic       unbal4;
    logic       inv4;
    logic [3:0] fghj;

    // Encode 5b/6b from the incoming RD, then 3b/4b from the intermediate RD.
    always_comb begin
        k_err  = k && !k_code_ok(data);
        // An unsupported K is replaced by the comma so the link keeps its alignment.
        code   = k_err ? K28_5 : data;
        x      = code[4:0];
        y      = code[7:5];
        k28    = k && (x == 5'd28);

        t6     = k28 ? {1'b1, 6'b001111} : code6_neg(x);
        // D.07 is balanced but still alternates its form with RD to bound run length.
        inv6   = (rd_in == RD_POS) && (t6[6] || (x == 5'd7));
        abcdei = inv6 ? ~t6[5:0] : t6[5:0];
        rd_mid = t6[6] ? ((rd_in == RD_POS) ? RD_NEG : RD_POS) : rd_in;

        // A7 avoids a run of five identical bits across the e/i-f boundary.
        alt7   = k ||
                 ((rd_mid == RD_NEG) && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                 ((rd_mid == RD_POS) && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
        case (y)
            3'd0:    fghj_neg = 4'b1011;
            3'd1:    fghj_neg = 4'b1001;
            3'd2:    fghj_neg = 4'b0101;
            3'd3:    fghj_neg = 4'b1100;
            3'd4:    fghj_neg = 4'b1101;
            3'd5:    fghj_neg = 4'b1010;
            3'd6:    fghj_neg = 4'b0110;
            default: fghj_neg = alt7 ? 4'b0111 : 4'b1110;
        endcase
        unbal4 = (y == 3'd0) || (y == 3'd4) || (y == 3'd7);
        // K28.1/.2/.5/.6 flip their balanced 4b form when the 6b half left RD-.
        if (rd_mid == RD_POS) begin
            inv4 = unbal4 || (y == 3'd3);
        end else begin
            inv4 = k28 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6));
        end
        fghj   = inv4 ? ~fghj_neg : fghj_neg;

        symbol = {abcdei, fghj};
        rd_out = unbal4 ? ((rd_mid == RD_POS) ? RD_NEG : RD_POS) : rd_mid;
    end

endmodule

// File: rtl/lane_encoder_8b10b.sv
// Per-lane 8b/10b encoder with running-disparity state and one output register.
// Latency: 1 clk from a valid byte to its symbol on data_out.
// Backpressure: none; valid_in low holds symbol and RD and drops valid_out.
module lane_encoder_8b10b
    import aurora_pkg::*;
#(
    // Only the 8-bit byte / 10-bit symbol pairing is supported.
    parameter int DATA_IN_SIZE  = ENCODER_DATA_IN_SIZE,
    parameter int DATA_OUT_SIZE = ENCODER_DATA_OUT_SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic                     ctrl_in,
    input  logic [DATA_IN_SIZE-1:0]  data_in,
    output logic                     valid_out,
    output logic [DATA_OUT_SIZE-1:0] data_out,
    output logic                     rd_out,
    output logic                     code_err
);

    rd_e                      rd_q;
    logic [DATA_OUT_SIZE-1:0] enc_symbol;
    rd_e                      enc_rd;
    logic                     enc_k_err;

    enc_5b6b_3b4b u_enc (
        .data   (data_in),
        .k      (ctrl_in),
        .rd_in  (rd_q),
        .symbol (enc_symbol),
        .rd_out (enc_rd),
        .k_err  (enc_k_err)
    );

    // Register the symbol and chain RD on every valid byte; idle cycles hold both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            rd_q      <= RD_NEG;
            code_err  <= 1'b0;
        end else if (valid_in) begin
            valid_out <= 1'b1;
            data_out  <= enc_symbol;
            rd_q      <= enc_rd;
            code_err  <= enc_k_err;
        end else begin
            valid_out <= 1'b0;
            code_err  <= 1'b0;
        end
    end

    assign rd_out = (rd_q == RD_POS);

endmodule
